// File: rtl/matrix_write_scheduler.sv
// Pixel write-port scheduler for the LED matrix driver: merges a sync-framed host
// byte stream with an internal moving-dot test pattern that runs while the host is silent.
module matrix_write_scheduler #(
    parameter int         PIXELS          = 192,
    parameter int         ADDR_WIDTH      = 9,
    parameter logic [7:0] SYNC_BYTE       = 8'hA5,
    parameter int         HOST_TIMEOUT    = 1200,
    parameter int         PATTERN_TIMEOUT = 12000000,
    parameter int         PATTERN_PERIOD  = 1200000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            host_data,
    input  logic                  host_valid,
    output logic                  host_ready,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic [7:0]            data_out,
    output logic                  write_strobe_out,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic                  sync_error,
    output logic                  pattern_active
);

    localparam int STALL_W  = $clog2(HOST_TIMEOUT) + 1;
    localparam int SIL_W    = $clog2(PATTERN_TIMEOUT) + 1;
    localparam int PERIOD_W = $clog2(PATTERN_PERIOD) + 1;

    localparam logic [ADDR_WIDTH-1:0] LAST_PIX    = ADDR_WIDTH'(PIXELS - 1);
    localparam logic [STALL_W-1:0]    STALL_LAST  = STALL_W'(HOST_TIMEOUT - 1);
    localparam logic [SIL_W-1:0]      SIL_LAST    = SIL_W'(PATTERN_TIMEOUT - 1);
    localparam logic [PERIOD_W-1:0]   PERIOD_LAST = PERIOD_W'(PATTERN_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOST,
        PAT_WRITE
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pix_idx;
    logic [ADDR_WIDTH-1:0]   pat_pos;
    logic [STALL_W-1:0]      stall_cnt;
    logic [SIL_W-1:0]        silence_cnt;
    logic [PERIOD_W-1:0]     period_cnt;

    logic accept;
    logic period_hit;

    assign accept     = host_valid && host_ready;
    assign period_hit = pattern_active && (period_cnt == PERIOD_LAST);

    // NOTE: every register here, including the state, is updated with non-blocking
    // assignments so later statements in this block always see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pix_idx          <= '0;
            pat_pos          <= '0;
            stall_cnt        <= '0;
            silence_cnt      <= '0;
            period_cnt       <= '0;
            host_ready       <= 1'b0;
            address_out      <= '0;
            data_out         <= '0;
            write_strobe_out <= 1'b0;
            frame_done       <= 1'b0;
            frame_abort      <= 1'b0;
            sync_error       <= 1'b0;
            pattern_active   <= 1'b0;
        end else begin
            write_strobe_out <= 1'b0;
            frame_done       <= 1'b0;
            frame_abort      <= 1'b0;
            sync_error       <= 1'b0;

            // The pattern period keeps ticking through pattern frames but freezes in HOST.
            if (pattern_active && state != HOST) begin
                period_cnt <= period_hit ? '0 : period_cnt + PERIOD_W'(1);
            end

            case (state)
                IDLE: begin
                    host_ready <= 1'b1;
                    if (accept) begin
                        silence_cnt <= '0;
                    end else if (!pattern_active) begin
                        if (silence_cnt == SIL_LAST) begin
                            pattern_active <= 1'b1;
                            period_cnt     <= PERIOD_LAST;
                            silence_cnt    <= '0;
                        end else begin
                            silence_cnt <= silence_cnt + SIL_W'(1);
                        end
                    end

                    // A sync byte beats a simultaneous period expiry.
                    if (accept && host_data == SYNC_BYTE) begin
                        state          <= HOST;
                        pix_idx        <= '0;
                        stall_cnt      <= '0;
                        pattern_active <= 1'b0;
                    end else begin
                        if (accept) begin
                            sync_error <= 1'b1;
                        end
                        if (period_hit) begin
                            state      <= PAT_WRITE;
                            pix_idx    <= '0;
                            host_ready <= 1'b0;
                        end
                    end
                end

                HOST: begin
                    host_ready <= 1'b1;
                    if (accept) begin
                        silence_cnt      <= '0;
                        stall_cnt        <= '0;
                        write_strobe_out <= 1'b1;
                        address_out      <= pix_idx;
                        data_out         <= host_data;
                        if (pix_idx == LAST_PIX) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            pix_idx <= pix_idx + ADDR_WIDTH'(1);
                        end
                    end else if (stall_cnt == STALL_LAST) begin
                        frame_abort <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                end

                PAT_WRITE: begin
                    host_ready       <= 1'b0;
                    write_strobe_out <= 1'b1;
                    address_out      <= pix_idx;
                    data_out         <= (pix_idx == pat_pos) ? 8'hFF : 8'h00;
                    if (pix_idx == LAST_PIX) begin
                        state      <= IDLE;
                        host_ready <= 1'b1;
                        pat_pos    <= (pat_pos == LAST_PIX) ? '0 : pat_pos + ADDR_WIDTH'(1);
                    end else begin
                        pix_idx <= pix_idx + ADDR_WIDTH'(1);
                    end
                end

                default: begin
                    state      <= IDLE;
                    host_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
